// File: rtl/maxnet_controller.sv
// maxnet_controller: sequencing FSM for the four-neuron MaxNet datapath.
// Optional iteration limit is enabled by defining MAXNET_CTRL_TIMEOUT_EN.
module maxnet_controller #(
  parameter int unsigned MUL_WAIT = 2,
  parameter int unsigned ITER_W   = 8,
  parameter int unsigned MAX_ITER = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ack,
  input  logic              dp_done,
  output logic              ldI,
  output logic              ldInit,
  output logic              ldM,
  output logic              ldRes,
  output logic              ldA,
  output logic              ready,
  output logic              busy,
  output logic              valid,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_INIT, S_MUL, S_WAIT, S_ACC, S_UPD, S_CHK, S_DONE
  } state_e;

  localparam int unsigned WAIT_LD = (MUL_WAIT > 0) ? MUL_WAIT - 1 : 0;

  if (MUL_WAIT > 15) begin : g_bad_mul_wait
    $error("maxnet_controller: MUL_WAIT must be in 0..15");
  end
  if (MAX_ITER < 1 || MAX_ITER > (2 ** ITER_W) - 1) begin : g_bad_max_iter
    $error("maxnet_controller: MAX_ITER must be in 1..2^ITER_W-1");
  end

  state_e            state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              timeout_q, timeout_d;
  logic              at_limit;

`ifdef MAXNET_CTRL_TIMEOUT_EN
  assign at_limit = (iter_q == ITER_W'(MAX_ITER));
`else
  assign at_limit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      iter_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      iter_q    <= iter_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    iter_d    = iter_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          iter_d    = '0;
          timeout_d = 1'b0;
        end
      end
      S_LOAD: state_d = S_INIT;
      S_INIT: state_d = S_CHK;
      S_MUL: begin
        if (MUL_WAIT > 0) begin
          state_d = S_WAIT;
          wait_d  = 4'(WAIT_LD);
        end else begin
          state_d = S_ACC;
        end
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_ACC;
        else              wait_d  = wait_q - 4'd1;
      end
      S_ACC: state_d = S_UPD;
      S_UPD: begin
        state_d = S_CHK;
        if (iter_q != '1) iter_d = iter_q + 1'b1;
      end
      // dp_done wins over the iteration limit when both hold in the same CHK
      S_CHK: begin
        if (dp_done) begin
          state_d = S_DONE;
        end else if (at_limit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DONE: begin
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ldI    = 1'b0;
    ldInit = 1'b0;
    ldM    = 1'b0;
    ldRes  = 1'b0;
    ldA    = 1'b0;
    ready  = 1'b0;
    busy   = 1'b0;
    valid  = 1'b0;
    unique case (state_q)
      S_IDLE: ready = 1'b1;
      S_LOAD: begin ldI = 1'b1;    busy = 1'b1; end
      S_INIT: begin ldInit = 1'b1; busy = 1'b1; end
      S_MUL:  begin ldM = 1'b1;    busy = 1'b1; end
      S_WAIT: busy = 1'b1;
      S_ACC:  begin ldRes = 1'b1;  busy = 1'b1; end
      S_UPD:  begin ldA = 1'b1;    busy = 1'b1; end
      S_CHK:  busy = 1'b1;
      S_DONE: valid = 1'b1;
      default: ;
    endcase
  end

  assign timeout    = timeout_q;
  assign iter_count = iter_q;

endmodule

// File: doc/maxnet_controller.md
# maxnet_controller

Sequencing FSM for the four-neuron MaxNet datapath. It accepts a start request, loads the four input samples, and initialises the activation registers. It then iterates the multiply, accumulate and activation-update cycle until the datapath reports a single surviving activation, and returns a valid/ack-handshaked completion. It sits directly above the datapath and drives all of its load strobes.

## Interface
Parameters:
- MUL_WAIT, 2: extra settle cycles between ldM and ldRes, covering the multi-cycle float multiply/add path; legal range 0..15.
- ITER_W, 8: width of the iteration counter.
- MAX_ITER, 100: iteration limit used by the timeout feature; must be at least 1 and no more than 2^ITER_W-1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to run; sampled only while ready=1.
- ack  in  1  consumer accepts the result; sampled only while valid=1.
- dp_done  in  1  datapath Done (exactly three activations zero).
- ldI  out  1  load input registers x1..x4.
- ldInit  out  1  load activation registers from initial values.
- ldM  out  1  load PU multiplier stage.
- ldRes  out  1  load PU result stage.
- ldA  out  1  load activation registers from PU outputs.
- ready  out  1  idle, start accepted.
- busy  out  1  run in progress.
- valid  out  1  result (datapath max) stable; held until ack.
- timeout  out  1  run ended by iteration limit; qualified by valid.
- iter_count  out  ITER_W  completed update iterations of the current or last run.

## Operation
- States: IDLE, LOAD, INIT, MUL, WAIT, ACC, UPD, CHK, DONE.
- IDLE: ready=1. On start=1, go to LOAD, clear iter_count and clear timeout.
- LOAD: ldI=1 for one cycle, then INIT.
- INIT: ldInit=1 for one cycle, then CHK. Inputs that are already converged finish with iter_count=0.
- MUL: ldM=1 for one cycle. Go to WAIT if MUL_WAIT>0, otherwise go to ACC.
- WAIT: down-counter loaded with MUL_WAIT-1 on entry. Stay until the counter reaches 0, then go to ACC. No strobes are asserted.
- ACC: ldRes=1 for one cycle, then UPD.
- UPD: ldA=1 for one cycle, iter_count increments by 1 (saturating at 2^ITER_W-1), then CHK.
- CHK: no strobes. Exits are checked in this priority order:
  - dp_done=1: go to DONE.
  - Timeout condition (see Configuration): go to DONE with timeout=1.
  - Otherwise: go to MUL.
- DONE: valid=1 and busy=0. On ack=1, go to IDLE; valid drops in the following cycle.
- Strobe rules:
  - At most one of ldI, ldInit, ldM, ldRes, ldA is high in any cycle.
  - Every strobe is a one-cycle pulse, driven by a Moore decode of the registered state.
- start while not in IDLE is ignored. ack outside DONE is ignored.
- iter_count and timeout hold their values through DONE and IDLE until the next accepted start.
- busy=1 in LOAD through CHK inclusive.

## Timing
- Reset values: all strobes 0, ready=1, busy=0, valid=0, timeout=0, iter_count=0, state IDLE.
- rst asserted mid-run aborts immediately (asynchronous) to those values. No strobe may glitch high during reset.
- start accepted in cycle t gives:
  - ldI in t+1.
  - ldInit in t+2.
  - CHK in t+3.
  - valid in t+4 if dp_done=1 in t+3.
- One iteration lasts 4+MUL_WAIT cycles, counted from MUL to CHK.
- Total latency for N iterations: 4 + N*(4+MUL_WAIT) cycles from start acceptance to valid.
- dp_done is sampled only in CHK, one cycle after ldA, so the activation registers are already updated.
- start and ack arriving in the same cycle: only the one relevant to the current state has an effect. ack in DONE always returns to IDLE, and start is not accepted until ready=1 again.

## Configuration
- MAXNET_CTRL_TIMEOUT_EN defined:
  - In CHK, with dp_done=0 and iter_count==MAX_ITER, go to DONE with timeout=1.
  - This guarantees termination for tied maximum inputs.
- Not defined:
  - No iteration limit; the FSM loops until dp_done.
  - timeout is constant 0.
  - iter_count still counts and saturates.

## Test plan
- Reset: assert rst mid-WAIT with MUL_WAIT=2 -> all strobes 0, ready=1, iter_count=0 in the same cycle; after release, start is accepted normally.
- Pre-converged input: dp_done held at 1, start at t -> ldI at t+1, ldInit at t+2, valid at t+4, iter_count=0, no ldM pulses.
- Three iterations: dp_done rises in the third CHK, MUL_WAIT=2 -> exactly 3 each of ldM, ldRes and ldA; valid at t+4+18=t+22; iter_count=3; strobes mutually exclusive every cycle.
- MUL_WAIT=0: one iteration -> ldRes directly after ldM, iteration length 4 cycles, valid at t+8.
- Timeout (macro on, MAX_ITER=5): dp_done held at 0 -> valid with timeout=1, iter_count=5. With the macro off, no valid after 500 cycles.
- Handshake: start pulsed during busy is ignored. Valid is held 10 cycles without ack, then ack -> IDLE the next cycle, and timeout and iter_count are retained until the next start.
